exu_redirect_ctrl: RTL and testbench

//  Sequences front-end redirects produced in EXU. Takes branch/jump mispredict requests from the

---
 rtl/exu_redirect_ctrl_if.sv | 28 ++
 rtl/exu_redirect_ctrl.sv | 118 +++++++++++
 tb/tb_exu_redirect_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/exu_redirect_ctrl_if.sv
// Redirect request/handshake bundle between BJU/trap sources, the redirect controller and the IFU.
// The master side is the controller; the slave side is the surrounding pipeline.
interface exu_redirect_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
);
  logic              bju_taken;
  logic [XLEN-1:0]   bju_jaddr;
  logic              trap_req;
  logic [XLEN-1:0]   trap_addr;
  logic              redirect_vld;
  logic [XLEN-1:0]   redirect_addr;
  logic              redirect_src;
  logic              redirect_rdy;
  logic              flush;
  logic              stall_issue;
  logic [STAT_W-1:0] bju_redir_cnt;

  modport master (
    input  bju_taken, bju_jaddr, trap_req, trap_addr, redirect_rdy,
    output redirect_vld, redirect_addr, redirect_src, flush, stall_issue, bju_redir_cnt
  );

  modport slave (
    output bju_taken, bju_jaddr, trap_req, trap_addr, redirect_rdy,
    input  redirect_vld, redirect_addr, redirect_src, flush, stall_issue, bju_redir_cnt
  );
endinterface

// File: rtl/exu_redirect_ctrl.sv
// Prioritises trap over BJU redirects, holds one on vld/rdy to the IFU, pulses flush, stalls issue.
// Request to vld/flush: 1 cycle; redirect held while !rdy, then issue stays stalled FLUSH_CYCLES.
module exu_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2,
  parameter int STAT_W       = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  exu_redirect_ctrl_if.master io
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DRAIN} state_t;

  localparam logic [CNT_W-1:0]  DRAIN_INIT = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              src_q, src_d;
  logic              vld_q, vld_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              accept;

  assign accept = vld_q & io.redirect_rdy;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    src_d   = src_q;
    vld_d   = vld_q;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    stat_d  = stat_q;
    case (state_q)
      IDLE: begin
        if (io.trap_req || io.bju_taken) begin
          state_d = WAIT_ACK;
          vld_d   = 1'b1;
          flush_d = 1'b1;
          src_d   = io.trap_req;
          addr_d  = io.trap_req ? io.trap_addr : io.bju_jaddr;
        end
      end
      WAIT_ACK: begin
        if (accept) begin
          if (!src_q && stat_q != STAT_MAX) stat_d = stat_q + STAT_W'(1);
          // A trap arriving with the handshake starts a fresh redirect immediately.
          if (io.trap_req) begin
            addr_d  = io.trap_addr;
            src_d   = 1'b1;
            flush_d = 1'b1;
          end else if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_INIT;
            vld_d   = 1'b0;
          end
        end else if (io.trap_req && !src_q) begin
          // Trap preempts a pending BJU redirect; a pending trap is never replaced.
          addr_d  = io.trap_addr;
          src_d   = 1'b1;
          flush_d = 1'b1;
        end
      end
      DRAIN: begin
        if (io.trap_req) begin
          state_d = WAIT_ACK;
          vld_d   = 1'b1;
          flush_d = 1'b1;
          src_d   = 1'b1;
          addr_d  = io.trap_addr;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      src_q   <= 1'b0;
      vld_q   <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      vld_q   <= vld_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

  assign io.redirect_vld  = vld_q;
  assign io.redirect_addr = addr_q;
  assign io.redirect_src  = src_q;
  assign io.flush         = flush_q;
  assign io.stall_issue   = (state_q != IDLE);
  assign io.bju_redir_cnt = stat_q;

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Bench for exu_redirect_ctrl: a FLUSH_CYCLES=2 instance and a FLUSH_CYCLES=0 / 2-bit-counter
// instance, with accepted redirects checked against a queue of expected targets.
module tb_exu_redirect_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic        src;
  } redir_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  redir_t q_a[$];
  redir_t q_b[$];

  always #5 i_clk = ~i_clk;

  exu_redirect_ctrl_if #(.XLEN(32), .STAT_W(16)) ifa ();
  exu_redirect_ctrl_if #(.XLEN(32), .STAT_W(2))  ifb ();

  exu_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2), .STAT_W(16)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .io(ifa.master));
  exu_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(2), .STAT_W(2)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .io(ifb.master));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: every handshake must match the oldest outstanding expected redirect.
  always @(negedge i_clk) begin
    if (!i_rst && ifa.redirect_vld && ifa.redirect_rdy) begin
      chk("a_q_nonempty", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        redir_t e;
        e = q_a.pop_front();
        chk("a_addr", 64'(ifa.redirect_addr), 64'(e.addr));
        chk("a_src", 64'(ifa.redirect_src), 64'(e.src));
      end
    end
    if (!i_rst && ifb.redirect_vld && ifb.redirect_rdy) begin
      chk("b_q_nonempty", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        redir_t e;
        e = q_b.pop_front();
        chk("b_addr", 64'(ifb.redirect_addr), 64'(e.addr));
        chk("b_src", 64'(ifb.redirect_src), 64'(e.src));
      end
    end
  end

  task automatic chk_a(input string tag, input logic vld, input logic flush, input logic stall);
    chk({tag, "_vld"}, 64'(ifa.redirect_vld), 64'(vld));
    chk({tag, "_flush"}, 64'(ifa.flush), 64'(flush));
    chk({tag, "_stall"}, 64'(ifa.stall_issue), 64'(stall));
  endtask

  initial begin
    int exp_cnt;
    ifa.bju_taken = 0; ifa.bju_jaddr = '0; ifa.trap_req = 0; ifa.trap_addr = '0; ifa.redirect_rdy = 0;
    ifb.bju_taken = 0; ifb.bju_jaddr = '0; ifb.trap_req = 0; ifb.trap_addr = '0; ifb.redirect_rdy = 0;
    #12;
    chk_a("rst_a", 1'b0, 1'b0, 1'b0);
    chk("rst_a_addr", 64'(ifa.redirect_addr), 64'd0);
    chk("rst_a_cnt", 64'(ifa.bju_redir_cnt), 64'd0);
    chk("rst_b_stall", 64'(ifb.stall_issue), 64'd0);
    tick();
    i_rst = 0;
    tick();

    // Plain BJU redirect, accepted immediately, then two drain cycles.
    ifa.bju_taken = 1; ifa.bju_jaddr = 32'h0000_1000; q_a.push_back('{32'h0000_1000, 1'b0});
    tick();
    ifa.bju_taken = 0;
    chk_a("t1_c1", 1'b1, 1'b1, 1'b1);
    ifa.redirect_rdy = 1;
    tick();
    ifa.redirect_rdy = 0;
    chk_a("t1_c2", 1'b0, 1'b0, 1'b1);
    chk("t1_cnt", 64'(ifa.bju_redir_cnt), 64'd1);
    tick();
    chk_a("t1_c3", 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("t1_c4", 1'b0, 1'b0, 1'b0);

    // Trap and BJU in the same cycle: trap wins, counter unchanged.
    ifa.trap_req = 1; ifa.trap_addr = 32'h8000_0000; ifa.bju_taken = 1; ifa.bju_jaddr = 32'h2000;
    q_a.push_back('{32'h8000_0000, 1'b1});
    tick();
    ifa.trap_req = 0; ifa.bju_taken = 0;
    chk_a("t2_c1", 1'b1, 1'b1, 1'b1);
    chk("t2_src", 64'(ifa.redirect_src), 64'd1);
    ifa.redirect_rdy = 1;
    tick();
    ifa.redirect_rdy = 0;
    chk("t2_cnt", 64'(ifa.bju_redir_cnt), 64'd1);
    tick(); tick();
    chk("t2_idle", 64'(ifa.stall_issue), 64'd0);

    // BJU held off by rdy=0, then preempted by a trap with a second flush.
    ifa.bju_taken = 1; ifa.bju_jaddr = 32'h2000; q_a.push_back('{32'h0000_2000, 1'b0});
    tick();
    ifa.bju_taken = 0;
    chk("t3_flush1", 64'(ifa.flush), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("t3_hold", 1'b1, 1'b0, 1'b1);
      chk("t3_hold_addr", 64'(ifa.redirect_addr), 64'h2000);
    end
    ifa.trap_req = 1; ifa.trap_addr = 32'h8000_0000;
    void'(q_a.pop_back()); q_a.push_back('{32'h8000_0000, 1'b1});
    tick();
    ifa.trap_req = 0;
    chk_a("t3_pre", 1'b1, 1'b1, 1'b1);
    chk("t3_pre_addr", 64'(ifa.redirect_addr), 64'h8000_0000);
    ifa.redirect_rdy = 1;
    tick();
    ifa.redirect_rdy = 0;
    chk("t3_cnt", 64'(ifa.bju_redir_cnt), 64'd1);
    tick(); tick();

    // Younger BJU requests during WAIT_ACK and DRAIN are ignored.
    ifa.bju_taken = 1; ifa.bju_jaddr = 32'h3000; q_a.push_back('{32'h0000_3000, 1'b0});
    tick();
    ifa.bju_jaddr = 32'h4000;
    tick();
    chk_a("t4_wait", 1'b1, 1'b0, 1'b1);
    chk("t4_addr", 64'(ifa.redirect_addr), 64'h3000);
    ifa.redirect_rdy = 1; ifa.bju_jaddr = 32'h5000;
    tick();
    ifa.redirect_rdy = 0;
    chk("t4_cnt", 64'(ifa.bju_redir_cnt), 64'd2);
    tick();
    chk_a("t4_drain", 1'b0, 1'b0, 1'b1);
    tick();
    ifa.bju_taken = 0;
    chk_a("t4_idle", 1'b0, 1'b0, 1'b0);
    tick();

    // Second trap ignored while one is pending; trap with handshake; trap abandons drain.
    ifa.trap_req = 1; ifa.trap_addr = 32'h100; q_a.push_back('{32'h0000_0100, 1'b1});
    tick();
    ifa.trap_addr = 32'h200;
    tick();
    chk_a("t5_ign", 1'b1, 1'b0, 1'b1);
    chk("t5_addr", 64'(ifa.redirect_addr), 64'h100);
    ifa.trap_addr = 32'h300; ifa.redirect_rdy = 1; q_a.push_back('{32'h0000_0300, 1'b1});
    tick();
    ifa.trap_req = 0;
    chk_a("t5_back", 1'b1, 1'b1, 1'b1);
    tick();
    chk_a("t5_drain", 1'b0, 1'b0, 1'b1);
    ifa.redirect_rdy = 0; ifa.trap_req = 1; ifa.trap_addr = 32'h400; q_a.push_back('{32'h0000_0400, 1'b1});
    tick();
    ifa.trap_req = 0;
    chk_a("t5_abandon", 1'b1, 1'b1, 1'b1);
    ifa.redirect_rdy = 1;
    tick();
    ifa.redirect_rdy = 0;
    tick(); tick();
    chk("t5_cnt", 64'(ifa.bju_redir_cnt), 64'd2);

    // Asynchronous reset mid-handshake drops the request.
    ifa.bju_taken = 1; ifa.bju_jaddr = 32'h6000;
    tick();
    ifa.bju_taken = 0;
    chk("t6_vld", 64'(ifa.redirect_vld), 64'd1);
    #2 i_rst = 1;
    #1;
    chk_a("t6_rst", 1'b0, 1'b0, 1'b0);
    chk("t6_addr", 64'(ifa.redirect_addr), 64'd0);
    chk("t6_cnt", 64'(ifa.bju_redir_cnt), 64'd0);
    tick();
    i_rst = 0;
    tick();

    // Zero-drain build: stall drops the cycle after accept; 2-bit counter saturates.
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ifb.bju_taken = 1; ifb.bju_jaddr = 32'h10 + 32'(i); q_b.push_back('{32'h10 + 32'(i), 1'b0});
      tick();
      ifb.bju_taken = 0;
      chk("b_vld", 64'(ifb.redirect_vld), 64'd1);
      ifb.redirect_rdy = 1;
      tick();
      ifb.redirect_rdy = 0;
      if (exp_cnt < 3) exp_cnt++;
      chk("b_stall", 64'(ifb.stall_issue), 64'd0);
      chk("b_cnt", 64'(ifb.bju_redir_cnt), 64'(exp_cnt));
    end

    tick();
    chk("a_q_drained", 64'(q_a.size()), 64'd0);
    chk("b_q_drained", 64'(q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
